stage_phase_accumulator: RTL
============================

# stage_phase_accumulator

Upstream neighbour of the modulator stage: the first stage of the voice-operator pipeline. A free-running slot sequencer visits one voice-operator slot per clock. Each visit presents that slot's raw unsigned 16-bit phase, note-on flag and ID to the modulator, then advances the slot's phase accumulator by its configured phase step. Phase steps and note-on flags are written by the configuration bus; a note-on rising edge retriggers the slot's phase to zero.

## Interface
- NUM_VOICES, 16, number of voices
- NUM_OPERATORS, 8, operators per voice; slot ID = voice*NUM_OPERATORS + operator (makeVoiceOperatorID ordering)
- NUM_SLOTS, NUM_VOICES*NUM_OPERATORS, derived; one frame = NUM_SLOTS clocks
- ACC_WIDTH, 24, accumulator width; must be ≥ 17
- i_Clock  in  1  sole clock
- i_Reset  in  1  asynchronous, active-high reset
- i_PhaseStepWriteEnable  in  1  write i_ConfigWriteData into phase step of slot i_ConfigWriteAddr
- i_NoteOnWriteEnable  in  1  write i_ConfigWriteData[0] into note-on flag of slot i_ConfigWriteAddr
- i_ConfigWriteAddr  in  VoiceOperatorID_t  target slot
- i_ConfigWriteData  in  16  unsigned phase step, or note-on in bit 0
- o_Phase  out  16  unsigned phase of serviced slot = accumulator[ACC_WIDTH-1 -: 16]
- o_NoteOn  out  1  note-on flag of serviced slot
- o_VoiceOperator  out  VoiceOperatorID_t  serviced slot ID
- o_FrameStart  out  1  high when o_VoiceOperator == 0

## Operation
- State: slot counter r_Slot (0..NUM_SLOTS-1); per slot: r_Accum (ACC_WIDTH, unsigned), r_Step (16), r_NoteOn (1), r_NoteOnSeen (1).
- Counter increments every clock and wraps NUM_SLOTS-1 → 0; no stall, no enable.
- Visit of slot c (current r_Slot == c), all updated at the same edge:
  - retrigger = r_NoteOn[c] & ~r_NoteOnSeen[c].
  - o_Phase ← 0 if retrigger, else r_Accum[c] top 16 bits (value before this visit's increment).
  - r_Accum[c] ← (retrigger ? 0 : r_Accum[c]) + zero-extended r_Step[c], modulo 2^ACC_WIDTH (silent wrap, no saturation).
  - r_NoteOnSeen[c] ← r_NoteOn[c]; o_NoteOn ← r_NoteOn[c]; o_VoiceOperator ← c; o_FrameStart ← (c == 0).
- Note-off: accumulator keeps advancing (release phase continues); only rising edges retrigger.
- Edge detection is per visit: a note-on set and cleared between two visits of the same slot is not seen.
- Config writes affect only r_Step / r_NoteOn of the addressed slot; both enables high in one cycle: both writes occur (step gets full data, note-on gets bit 0).
- Write to the slot being visited in the same cycle: visit uses the old value; new value used from the next visit (one frame later).
- Write address ≥ NUM_SLOTS: ignored.

## Timing
- Outputs registered; latency 1 clock from slot selection to outputs; one slot presented per clock, continuously.
- Phase frequency per slot: step × f_clk / (NUM_SLOTS × 2^ACC_WIDTH); o_Phase advances step/2^(ACC_WIDTH-16) per frame.
- Reset (async assert, sync use after deassert): r_Slot=0, all r_Accum/r_Step/r_NoteOn/r_NoteOnSeen = 0; o_Phase=0, o_NoteOn=0, o_VoiceOperator=0, o_FrameStart=0. Config writes during reset are discarded.
- First edge after reset deassertion services slot 0: o_VoiceOperator=0, o_FrameStart=1.
- Reset mid-frame: all state cleared immediately; sequencing restarts at slot 0, no partial-frame output.

## Test plan
- Reset: hold i_Reset 5 clocks mid-frame -> all outputs 0 immediately; first edge after release o_VoiceOperator=0, o_FrameStart=1; slots then 1,2,… and o_FrameStart again exactly NUM_SLOTS clocks later.
- Step 0x0100 on slot 5, note-on slot 5 -> slot 5 o_Phase = 0,1,2,3… on successive frames (ACC_WIDTH=24); other slots remain 0, o_NoteOn=1 only on slot 5.
- Wrap: step 0x8000 on slot 3 -> o_Phase steps by 0x0080 per frame, 0xFF80 on visit 511, 0x0000 on visit 512.
- Retrigger: slot 2 running at step 0x1000, clear then set note-on across two frames -> visit after the set outputs o_Phase=0, next visit 0x0010, then 0x0020.
- Same-cycle write: write step 0x0200 to slot 7 in the cycle slot 7 is visited (old step 0x0100) -> that visit advances by 0x0100; subsequent visits by 0x0200.
- Dual write: both enables high, data 0x0101 to slot 9 -> step=0x0101, note-on=1, retrigger on next slot-9 visit.

Source files
------------

// File: rtl/stage_phase_accumulator.sv
// First voice-operator pipeline stage: visits one slot per clock, presents its
// phase/note-on/ID and advances the slot's phase accumulator by its step.
module stage_phase_accumulator #(
    parameter int NUM_VOICES    = 16,
    parameter int NUM_OPERATORS = 8,
    parameter int NUM_SLOTS     = NUM_VOICES * NUM_OPERATORS,
    parameter int ACC_WIDTH     = 24,
    parameter int ID_WIDTH      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic                i_PhaseStepWriteEnable,
    input  logic                i_NoteOnWriteEnable,
    input  logic [ID_WIDTH-1:0] i_ConfigWriteAddr,
    input  logic [15:0]         i_ConfigWriteData,
    output logic [15:0]         o_Phase,
    output logic                o_NoteOn,
    output logic [ID_WIDTH-1:0] o_VoiceOperator,
    output logic                o_FrameStart
);

    localparam logic [ID_WIDTH-1:0] LAST_SLOT  = ID_WIDTH'(NUM_SLOTS - 1);
    localparam logic [ID_WIDTH:0]   SLOT_LIMIT = (ID_WIDTH + 1)'(NUM_SLOTS);

    if (ACC_WIDTH < 17) begin : g_bad_acc_width
        $error("stage_phase_accumulator: ACC_WIDTH must be at least 17");
    end

    logic [ID_WIDTH-1:0]  r_Slot;
    logic [ACC_WIDTH-1:0] r_Accum [NUM_SLOTS];
    logic [15:0]          r_Step  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_NoteOn;
    logic [NUM_SLOTS-1:0] r_NoteOnSeen;

    logic                 w_Retrigger;
    logic [ACC_WIDTH-1:0] w_AccBase;
    logic [ACC_WIDTH-1:0] w_AccNext;
    logic                 w_AddrValid;

    // A note-on rising edge (as seen between two visits) restarts the phase at 0
    // for both the presented value and the base of this visit's increment.
    always_comb begin
        w_Retrigger = r_NoteOn[r_Slot] & ~r_NoteOnSeen[r_Slot];
        w_AccBase   = w_Retrigger ? '0 : r_Accum[r_Slot];
        w_AccNext   = w_AccBase + {{(ACC_WIDTH - 16){1'b0}}, r_Step[r_Slot]};
        w_AddrValid = ({1'b0, i_ConfigWriteAddr} < SLOT_LIMIT);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Slot          <= '0;
            r_NoteOnSeen    <= '0;
            o_Phase         <= '0;
            o_NoteOn        <= 1'b0;
            o_VoiceOperator <= '0;
            o_FrameStart    <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                r_Accum[i] <= '0;
            end
        end else begin
            r_Slot               <= (r_Slot == LAST_SLOT) ? '0 : r_Slot + 1'b1;
            o_Phase              <= w_AccBase[ACC_WIDTH-1 -: 16];
            o_NoteOn             <= r_NoteOn[r_Slot];
            o_VoiceOperator      <= r_Slot;
            o_FrameStart         <= (r_Slot == '0);
            r_Accum[r_Slot]      <= w_AccNext;
            r_NoteOnSeen[r_Slot] <= r_NoteOn[r_Slot];
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_NoteOn <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                r_Step[i] <= '0;
            end
        end else if (w_AddrValid) begin
            if (i_PhaseStepWriteEnable) begin
                r_Step[i_ConfigWriteAddr] <= i_ConfigWriteData;
            end
            if (i_NoteOnWriteEnable) begin
                r_NoteOn[i_ConfigWriteAddr] <= i_ConfigWriteData[0];
            end
        end
    end

endmodule
